// File: rtl/tlb.sv
// Fully associative joint TLB with two registered search ports and a CP0 read/write port.
// Optional macro TLB_MULTI_HIT_EN adds s0_multi/s1_multi multi-match flags.
module tlb #(
    parameter int TLBNUM       = 16,
    parameter int TLBNUM_WIDTH = $clog2(TLBNUM)
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    s0_req,
    input  logic [18:0]             s0_vpn2,
    input  logic                    s0_odd_page,
    input  logic [7:0]              s0_asid,
    output logic                    s0_found,
    output logic [TLBNUM_WIDTH-1:0] s0_index,
    output logic [19:0]             s0_pfn,
    output logic [2:0]              s0_c,
    output logic                    s0_d,
    output logic                    s0_v,
    input  logic                    s1_req,
    input  logic [18:0]             s1_vpn2,
    input  logic                    s1_odd_page,
    input  logic [7:0]              s1_asid,
    output logic                    s1_found,
    output logic [TLBNUM_WIDTH-1:0] s1_index,
    output logic [19:0]             s1_pfn,
    output logic [2:0]              s1_c,
    output logic                    s1_d,
    output logic                    s1_v,
    input  logic                    we,
    input  logic [TLBNUM_WIDTH-1:0] w_index,
    input  logic [18:0]             w_vpn2,
    input  logic [7:0]              w_asid,
    input  logic                    w_g,
    input  logic [19:0]             w_pfn0,
    input  logic [2:0]              w_c0,
    input  logic                    w_d0,
    input  logic                    w_v0,
    input  logic [19:0]             w_pfn1,
    input  logic [2:0]              w_c1,
    input  logic                    w_d1,
    input  logic                    w_v1,
    input  logic [TLBNUM_WIDTH-1:0] r_index,
    output logic [18:0]             r_vpn2,
    output logic [7:0]              r_asid,
    output logic                    r_g,
    output logic [19:0]             r_pfn0,
    output logic [2:0]              r_c0,
    output logic                    r_d0,
    output logic                    r_v0,
    output logic [19:0]             r_pfn1,
    output logic [2:0]              r_c1,
    output logic                    r_d1,
    output logic                    r_v1
`ifdef TLB_MULTI_HIT_EN
    ,
    output logic                    s0_multi,
    output logic                    s1_multi
`endif
);

    localparam logic [TLBNUM_WIDTH:0] IDX_LIMIT = (TLBNUM_WIDTH + 1)'(TLBNUM);

    typedef struct packed {
        logic                    found;
        logic [TLBNUM_WIDTH-1:0] index;
        logic [19:0]             pfn;
        logic [2:0]              c;
        logic                    d;
        logic                    v;
`ifdef TLB_MULTI_HIT_EN
        logic                    multi;
`endif
    } result_t;

    // Control bits that decide whether an entry can hit live in resettable flops.
    logic [TLBNUM-1:0] e_q, g_q, d0_q, v0_q, d1_q, v1_q;
    logic [18:0]       vpn2_q [TLBNUM];
    logic [7:0]        asid_q [TLBNUM];
    logic [19:0]       pfn0_q [TLBNUM];
    logic [19:0]       pfn1_q [TLBNUM];
    logic [2:0]        c0_q   [TLBNUM];
    logic [2:0]        c1_q   [TLBNUM];

    logic w_ok, r_ok;
    assign w_ok = we && ({1'b0, w_index} < IDX_LIMIT);
    assign r_ok = {1'b0, r_index} < IDX_LIMIT;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            e_q  <= '0;
            g_q  <= '0;
            d0_q <= '0;
            v0_q <= '0;
            d1_q <= '0;
            v1_q <= '0;
        end else if (w_ok) begin
            e_q[w_index]  <= 1'b1;
            g_q[w_index]  <= w_g;
            d0_q[w_index] <= w_d0;
            v0_q[w_index] <= w_v0;
            d1_q[w_index] <= w_d1;
            v1_q[w_index] <= w_v1;
        end
    end

    // NOTE: the wide payload array has no reset; E=0 already masks stale contents, and a reset here would cost a flop reset per bit.
    always_ff @(posedge clk) begin
        if (w_ok) begin
            vpn2_q[w_index] <= w_vpn2;
            asid_q[w_index] <= w_asid;
            pfn0_q[w_index] <= w_pfn0;
            c0_q[w_index]   <= w_c0;
            pfn1_q[w_index] <= w_pfn1;
            c1_q[w_index]   <= w_c1;
        end
    end

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
    always_comb begin
        r_vpn2 = '0; r_asid = '0; r_g  = 1'b0;
        r_pfn0 = '0; r_c0   = '0; r_d0 = 1'b0; r_v0 = 1'b0;
        r_pfn1 = '0; r_c1   = '0; r_d1 = 1'b0; r_v1 = 1'b0;
        if (r_ok) begin
            r_vpn2 = vpn2_q[r_index]; r_asid = asid_q[r_index]; r_g  = g_q[r_index];
            r_pfn0 = pfn0_q[r_index]; r_c0   = c0_q[r_index];   r_d0 = d0_q[r_index];
            r_v0   = v0_q[r_index];
            r_pfn1 = pfn1_q[r_index]; r_c1   = c1_q[r_index];   r_d1 = d1_q[r_index];
            r_v1   = v1_q[r_index];
        end
    end

    logic        s_req  [2];
    logic [18:0] s_vpn2 [2];
    logic        s_odd  [2];
    logic [7:0]  s_asid [2];
    assign s_req[0]  = s0_req;      assign s_req[1]  = s1_req;
    assign s_vpn2[0] = s0_vpn2;     assign s_vpn2[1] = s1_vpn2;
    assign s_odd[0]  = s0_odd_page; assign s_odd[1]  = s1_odd_page;
    assign s_asid[0] = s0_asid;     assign s_asid[1] = s1_asid;

    for (genvar p = 0; p < 2; p++) begin : g_port
        result_t res_d, res_q;

        // Scan from the top so the lowest matching index is the last to overwrite.
        always_comb begin
            res_d = '0;
            for (int i = TLBNUM - 1; i >= 0; i--) begin
                if (e_q[i] && vpn2_q[i] == s_vpn2[p] && (g_q[i] || asid_q[i] == s_asid[p])) begin
`ifdef TLB_MULTI_HIT_EN
                    res_d.multi = res_d.found;
`endif
                    res_d.found = 1'b1;
                    res_d.index = TLBNUM_WIDTH'(i);
                    res_d.pfn   = s_odd[p] ? pfn1_q[i] : pfn0_q[i];
                    res_d.c     = s_odd[p] ? c1_q[i]   : c0_q[i];
                    res_d.d     = s_odd[p] ? d1_q[i]   : d0_q[i];
                    res_d.v     = s_odd[p] ? v1_q[i]   : v0_q[i];
                end
            end
        end

        // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                res_q <= '0;
            end else if (s_req[p]) begin
                res_q <= res_d;
            end
        end
    end

    assign s0_found = g_port[0].res_q.found;
    assign s0_index = g_port[0].res_q.index;
    assign s0_pfn   = g_port[0].res_q.pfn;
    assign s0_c     = g_port[0].res_q.c;
    assign s0_d     = g_port[0].res_q.d;
    assign s0_v     = g_port[0].res_q.v;
    assign s1_found = g_port[1].res_q.found;
    assign s1_index = g_port[1].res_q.index;
    assign s1_pfn   = g_port[1].res_q.pfn;
    assign s1_c     = g_port[1].res_q.c;
    assign s1_d     = g_port[1].res_q.d;
    assign s1_v     = g_port[1].res_q.v;
`ifdef TLB_MULTI_HIT_EN
    assign s0_multi = g_port[0].res_q.multi;
    assign s1_multi = g_port[1].res_q.multi;
`endif

endmodule

// File: tb/tb_tlb.sv
// Scoreboard bench for tlb: directed writes/searches push expected results; a monitor checks them.
// Define TLB_MULTI_HIT_EN to also check the multi-match outputs.
module tb_tlb;

    localparam int TLBNUM = 16;
    localparam int IW     = 4;

    typedef struct packed {
        logic          found;
        logic [IW-1:0] index;
        logic [19:0]   pfn;
        logic [2:0]    c;
        logic          d;
        logic          v;
        logic          multi;
    } exp_t;

    logic          clk = 1'b0;
    logic          resetn;
    logic          s0_req, s1_req, s0_odd_page, s1_odd_page;
    logic [18:0]   s0_vpn2, s1_vpn2;
    logic [7:0]    s0_asid, s1_asid;
    logic          s0_found, s1_found, s0_d, s1_d, s0_v, s1_v;
    logic [IW-1:0] s0_index, s1_index;
    logic [19:0]   s0_pfn, s1_pfn;
    logic [2:0]    s0_c, s1_c;
    logic          we, w_g, w_d0, w_v0, w_d1, w_v1;
    logic [IW-1:0] w_index, r_index;
    logic [18:0]   w_vpn2, r_vpn2;
    logic [7:0]    w_asid, r_asid;
    logic [19:0]   w_pfn0, w_pfn1, r_pfn0, r_pfn1;
    logic [2:0]    w_c0, w_c1, r_c0, r_c1;
    logic          r_g, r_d0, r_v0, r_d1, r_v1;
    logic          s0_multi_w, s1_multi_w;

    tlb #(.TLBNUM(TLBNUM)) dut (
        .clk(clk), .resetn(resetn),
        .s0_req(s0_req), .s0_vpn2(s0_vpn2), .s0_odd_page(s0_odd_page), .s0_asid(s0_asid),
        .s0_found(s0_found), .s0_index(s0_index), .s0_pfn(s0_pfn), .s0_c(s0_c), .s0_d(s0_d), .s0_v(s0_v),
        .s1_req(s1_req), .s1_vpn2(s1_vpn2), .s1_odd_page(s1_odd_page), .s1_asid(s1_asid),
        .s1_found(s1_found), .s1_index(s1_index), .s1_pfn(s1_pfn), .s1_c(s1_c), .s1_d(s1_d), .s1_v(s1_v),
        .we(we), .w_index(w_index), .w_vpn2(w_vpn2), .w_asid(w_asid), .w_g(w_g),
        .w_pfn0(w_pfn0), .w_c0(w_c0), .w_d0(w_d0), .w_v0(w_v0),
        .w_pfn1(w_pfn1), .w_c1(w_c1), .w_d1(w_d1), .w_v1(w_v1),
        .r_index(r_index), .r_vpn2(r_vpn2), .r_asid(r_asid), .r_g(r_g),
        .r_pfn0(r_pfn0), .r_c0(r_c0), .r_d0(r_d0), .r_v0(r_v0),
        .r_pfn1(r_pfn1), .r_c1(r_c1), .r_d1(r_d1), .r_v1(r_v1)
`ifdef TLB_MULTI_HIT_EN
        , .s0_multi(s0_multi_w), .s1_multi(s1_multi_w)
`endif
    );

`ifndef TLB_MULTI_HIT_EN
    assign s0_multi_w = 1'b0;
    assign s1_multi_w = 1'b0;
`endif

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    exp_t q0[$], q1[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic compare(input string port, input exp_t e, input logic found, input logic [IW-1:0] index,
                           input logic [19:0] pfn, input logic [2:0] c, input logic d, input logic v,
                           input logic multi);
        check({port, ".found"}, 64'(found), 64'(e.found));
        check({port, ".index"}, 64'(index), 64'(e.index));
        check({port, ".pfn"},   64'(pfn),   64'(e.pfn));
        check({port, ".c"},     64'(c),     64'(e.c));
        check({port, ".d"},     64'(d),     64'(e.d));
        check({port, ".v"},     64'(v),     64'(e.v));
`ifdef TLB_MULTI_HIT_EN
        check({port, ".multi"}, 64'(multi), 64'(e.multi));
`endif
    endtask

    // Monitor: a request seen at a posedge produces a result checked at the following negedge.
    logic p0, p1;
    always @(posedge clk) begin
        p0 = s0_req && resetn;
        p1 = s1_req && resetn;
        @(negedge clk);
        if (p0) begin
            if (q0.size() == 0) begin
                errors++; checks++;
                $display("FAIL s0 scoreboard: result with no expected entry");
            end else compare("s0", q0.pop_front(), s0_found, s0_index, s0_pfn, s0_c, s0_d, s0_v, s0_multi_w);
        end
        if (p1) begin
            if (q1.size() == 0) begin
                errors++; checks++;
                $display("FAIL s1 scoreboard: result with no expected entry");
            end else compare("s1", q1.pop_front(), s1_found, s1_index, s1_pfn, s1_c, s1_d, s1_v, s1_multi_w);
        end
    end

    function automatic exp_t mk(input logic f, input int idx, input logic [19:0] pfn, input logic [2:0] c,
                                input logic d, input logic v, input logic m);
        exp_t e;
        e.found = f; e.index = IW'(idx); e.pfn = pfn; e.c = c; e.d = d; e.v = v; e.multi = m;
        return e;
    endfunction

    localparam exp_t MISS = '0;

    // Drive window starts #1 after a posedge; each task advances one cycle.
    task automatic step();
        @(posedge clk);
        #1;
        we = 1'b0; s0_req = 1'b0; s1_req = 1'b0;
    endtask

    task automatic set_write(input int idx, input logic [18:0] vpn2, input logic [7:0] asid, input logic g,
                             input logic [19:0] pfn0, input logic [2:0] c0, input logic d0, input logic v0,
                             input logic [19:0] pfn1, input logic [2:0] c1, input logic d1, input logic v1);
        we = 1'b1; w_index = IW'(idx); w_vpn2 = vpn2; w_asid = asid; w_g = g;
        w_pfn0 = pfn0; w_c0 = c0; w_d0 = d0; w_v0 = v0;
        w_pfn1 = pfn1; w_c1 = c1; w_d1 = d1; w_v1 = v1;
    endtask

    task automatic set_s0(input logic [18:0] vpn2, input logic odd, input logic [7:0] asid, input exp_t e);
        s0_req = 1'b1; s0_vpn2 = vpn2; s0_odd_page = odd; s0_asid = asid;
        q0.push_back(e);
    endtask

    task automatic set_s1(input logic [18:0] vpn2, input logic odd, input logic [7:0] asid, input exp_t e);
        s1_req = 1'b1; s1_vpn2 = vpn2; s1_odd_page = odd; s1_asid = asid;
        q1.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0;
        {s0_req, s1_req, s0_odd_page, s1_odd_page, we, w_g, w_d0, w_v0, w_d1, w_v1} = '0;
        s0_vpn2 = '0; s1_vpn2 = '0; s0_asid = '0; s1_asid = '0;
        w_index = '0; r_index = '0; w_vpn2 = '0; w_asid = '0;
        w_pfn0 = '0; w_pfn1 = '0; w_c0 = '0; w_c1 = '0;
        #12;
        check("reset s0_found", 64'(s0_found), 64'd0);
        check("reset s1_pfn",   64'(s1_pfn),   64'd0);
        check("reset r_v0",     64'(r_v0),     64'd0);
        @(posedge clk); #1;
        resetn = 1'b1;
        step();

        set_s0(19'h00000, 1'b0, 8'h00, MISS); step();

        set_write(3, 19'h12345, 8'h05, 1'b0, 20'hABCDE, 3'd3, 1'b1, 1'b1, 20'h11111, 3'd0, 1'b0, 1'b0); step();
        set_s0(19'h12345, 1'b0, 8'h05, mk(1, 3, 20'hABCDE, 3'd3, 1, 1, 0)); step();
        set_s0(19'h12345, 1'b1, 8'h05, mk(1, 3, 20'h11111, 3'd0, 0, 0, 0)); step();
        set_s1(19'h12345, 1'b0, 8'h05, mk(1, 3, 20'hABCDE, 3'd3, 1, 1, 0)); step();

        r_index = 4'd3; #1;
        check("read idx3 vpn2", 64'(r_vpn2), 64'h12345);
        check("read idx3 pfn0", 64'(r_pfn0), 64'hABCDE);

        set_s0(19'h12345, 1'b0, 8'h06, MISS); step();
        set_write(3, 19'h12345, 8'h05, 1'b1, 20'hABCDE, 3'd3, 1'b1, 1'b1, 20'h11111, 3'd0, 1'b0, 1'b0); step();
        set_s0(19'h12345, 1'b0, 8'h06, mk(1, 3, 20'hABCDE, 3'd3, 1, 1, 0));
        set_s1(19'h12345, 1'b1, 8'h77, mk(1, 3, 20'h11111, 3'd0, 0, 0, 0)); step();

        // Duplicate tags in entries 9 and 2: lowest index must win.
        set_write(9, 19'h0ABCD, 8'h22, 1'b0, 20'h99990, 3'd2, 1'b0, 1'b1, 20'h99991, 3'd5, 1'b1, 1'b1); step();
        set_write(2, 19'h0ABCD, 8'h22, 1'b0, 20'h22220, 3'd4, 1'b1, 1'b0, 20'h22221, 3'd6, 1'b0, 1'b1); step();
        set_s1(19'h0ABCD, 1'b0, 8'h22, mk(1, 2, 20'h22220, 3'd4, 1, 0, 1));
        set_s0(19'h0ABCD, 1'b1, 8'h22, mk(1, 2, 20'h22221, 3'd6, 0, 1, 1)); step();
        step();
        check("hold s1_pfn", 64'(s1_pfn), 64'h22220);

        // Same-edge write, search and read of entry 5.
        set_write(5, 19'h00555, 8'h01, 1'b0, 20'h55550, 3'd1, 1'b0, 1'b1, 20'h55551, 3'd1, 1'b1, 1'b1); step();
        set_write(5, 19'h07777, 8'h01, 1'b0, 20'h77770, 3'd2, 1'b1, 1'b1, 20'h77771, 3'd2, 1'b0, 1'b0);
        set_s1(19'h07777, 1'b0, 8'h01, MISS);
        r_index = 4'd5; #1;
        check("same-cycle r_vpn2 old", 64'(r_vpn2), 64'h00555);
        check("same-cycle r_pfn0 old", 64'(r_pfn0), 64'h55550);
        step();
        check("next-cycle r_vpn2 new", 64'(r_vpn2), 64'h07777);
        check("next-cycle r_pfn0 new", 64'(r_pfn0), 64'h77770);
        set_s1(19'h07777, 1'b0, 8'h01, mk(1, 5, 20'h77770, 3'd2, 1, 1, 0)); step();

        // Asynchronous reset while a hit is held.
        set_s0(19'h12345, 1'b0, 8'h05, mk(1, 3, 20'hABCDE, 3'd3, 1, 1, 0)); step();
        @(negedge clk); #1;
        check("pre-reset s0_found", 64'(s0_found), 64'd1);
        resetn = 1'b0; #1;
        check("async reset s0_found", 64'(s0_found), 64'd0);
        check("async reset s0_pfn",   64'(s0_pfn),   64'd0);
        check("async reset s0_index", 64'(s0_index), 64'd0);
        @(posedge clk); #1;
        resetn = 1'b1;
        r_index = 4'd3; #1;
        check("post-reset r_v0", 64'(r_v0), 64'd0);
        check("post-reset r_g",  64'(r_g),  64'd0);
        set_s0(19'h12345, 1'b0, 8'h05, MISS); step();

        for (int k = 0; k < 20 && (q0.size() != 0 || q1.size() != 0); k++) @(posedge clk);
        @(negedge clk); #1;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++; checks++;
            $display("FAIL drain: %0d s0 and %0d s1 results never arrived", q0.size(), q1.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tlb.md
Name: tlb

Overview:
- Fully associative joint TLB, the responder side of the CP0 TLB write/read interface.
- Holds TLBNUM entries written by TLBWI/TLBWR and read back by TLBR.
- Serves two registered search ports: port 0 for fetch translation, port 1 for load/store translation and TLBP probe.
- Sits beside cp0; the MMU glue feeds its search ports from pre-IF and EX.

Parameters:
- TLBNUM, 16, number of entries (2..64).
- TLBNUM_WIDTH, $clog2(TLBNUM), index width.

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
- s0_req, s1_req  in  1  search request, sampled at posedge.
- s0_vpn2, s1_vpn2  in  19  VA[31:13].
- s0_odd_page, s1_odd_page  in  1  VA[12]; selects page 1 when 1.
- s0_asid, s1_asid  in  8  current ASID.
- s0_found, s1_found  out  1  registered hit.
- s0_index, s1_index  out  TLBNUM_WIDTH  registered hit index.
- s0_pfn, s1_pfn  out  20  registered PFN of the selected page.
- s0_c, s1_c  out  3  registered cache attribute.
- s0_d, s1_d  out  1  registered dirty bit.
- s0_v, s1_v  out  1  registered valid bit.
- we  in  1  write enable.
- w_index  in  TLBNUM_WIDTH  write index.
- w_vpn2, w_asid, w_g, w_pfn0, w_c0, w_d0, w_v0, w_pfn1, w_c1, w_d1, w_v1  in  19/8/1/20/3/1/1/20/3/1/1  entry fields.
- r_index  in  TLBNUM_WIDTH  read index.
- r_vpn2, r_asid, r_g, r_pfn0, r_c0, r_d0, r_v0, r_pfn1, r_c1, r_d1, r_v1  out  19/8/1/20/3/1/1/20/3/1/1  entry fields, combinational.

Behaviour:
- Storage: per entry, the fields above plus an internal written bit E.
- resetn low clears E, all V0/V1, D0/D1 and G in every entry.
- resetn low zeroes all s*_ outputs.
- Reset is asynchronous on assertion; deassertion takes effect at the following posedge.
- Write: at posedge with we=1 and w_index<TLBNUM, all fields of entry w_index are updated and E is set.
- we with w_index>=TLBNUM is ignored.
- Read: r_* reflect entry r_index combinationally from storage.
- r_index>=TLBNUM returns all zero.
- Same-cycle write and read of the same index return the old contents; the new value is visible the next cycle.
- Match for entry i: E_i && vpn2==VPN2_i && (G_i || asid==ASID_i).
- Hit select: lowest matching index wins.
- Page select: odd_page selects the PFN1/C1/D1/V1 set, otherwise the PFN0/C0/D0/V0 set.
- Search latency is 1 cycle. At a posedge with sN_req=1, the match uses storage as it was before that edge (a same-edge write is not seen). sN_found/index/pfn/c/d/v are registered.
- Miss: found=0; index, pfn, c, d and v = 0.
- When sN_req=0, search outputs hold their previous value.
- The two ports are fully independent and may hit the same entry in the same cycle.
- An entry whose page V bit is 0 still reports found=1 with v=0, so the MMU can tell TLB invalid from refill.
- TLBP: cp0 forms tlbp_result = {~s1_found, s1_index} in the cycle after it issues s1_req with the EntryHi VPN2/ASID.

Optional Feature:
- Macro: TLB_MULTI_HIT_EN.
- When defined:
  - Add outputs s0_multi and s1_multi (1 bit each).
  - Each is registered alongside its found, set when two or more entries match, and reset to 0.
  - Hit select is unchanged (lowest index).
- When undefined: the outputs are absent and no popcount logic is built.

Test Plan:
- Reset, then s0_req with vpn2=0x00000, asid=0 -> next cycle s0_found=0, s0_index=0, s0_pfn=0.
- Write idx 3 {vpn2=0x12345, asid=0x05, g=0, pfn0=0xABCDE, c0=3, d0=1, v0=1, pfn1=0x11111, v1=0}. Then s0 search vpn2=0x12345, odd=0, asid=5 -> found=1, index=3, pfn=0xABCDE, c=3, d=1, v=1. Same search with odd=1 -> pfn=0x11111, v=0, found=1.
- ASID/global: search idx 3 with asid=6 -> found=0. Rewrite idx 3 with g=1, then asid=6 -> found=1.
- Multiple matches: write identical vpn2/asid to idx 2 and idx 9 -> found=1, index=2. With TLB_MULTI_HIT_EN, s*_multi=1.
- Same-cycle write/search/read: we to idx 5 with a new vpn2, s1_req on that vpn2 and r_index=5 in the same cycle -> s1_found=0 and r_* show old data. Repeat next cycle -> s1_found=1, index=5, r_* show new data.
- Assert resetn low mid-search with s0_found=1 -> s0_found drops immediately. After release, a search for the old vpn2 -> found=0.
